// File: rtl/float_vector_result_collector.sv
// Result-line collector: buffers fixed-latency vector results in a FWFT FIFO and returns issue credits.
// Optional FLOAT_VECTOR_RESULT_COLLECTOR_STATS_EN adds delivered-line and stall-cycle counters.
module float_vector_result_collector #(
    parameter int unsigned VALUES_PER_LINE = 16,
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned CNT_W           = $clog2(DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          issue_valid,
    output logic                          issue_ready,
    input  logic [32*VALUES_PER_LINE-1:0] result,
    input  logic                          result_valid,
    output logic [32*VALUES_PER_LINE-1:0] out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [CNT_W-1:0]              occupancy,
    output logic [CNT_W-1:0]              inflight,
    output logic [1:0]                    error
`ifdef FLOAT_VECTOR_RESULT_COLLECTOR_STATS_EN
    ,
    output logic [31:0]                   lines_delivered,
    output logic [31:0]                   stall_cycles
`endif
);

    localparam int unsigned LINE_W = 32 * VALUES_PER_LINE;
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned RES_W  = CNT_W + 1;

    logic [LINE_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  wr_ptr_n, rd_ptr_n, inflight_n;
    logic [1:0]        error_n;
    logic [RES_W-1:0]  reserved;
    logic              full, empty, wr_en, issue_fire, out_fire;

    // Status and credits are derived from registered state only.
    assign occupancy   = wr_ptr - rd_ptr;
    assign full        = (occupancy == CNT_W'(DEPTH));
    assign empty       = (wr_ptr == rd_ptr);
    assign out_valid   = !empty;
    assign out_data    = mem[rd_ptr[ADDR_W-1:0]];
    assign reserved    = RES_W'(occupancy) + RES_W'(inflight);
    assign issue_ready = (reserved < RES_W'(DEPTH));

    assign issue_fire  = issue_valid & issue_ready;
    assign out_fire    = out_valid & out_ready;
    // A read in the same cycle never frees a slot for a write into a full buffer.
    assign wr_en       = result_valid & !full;

    always_comb begin
        wr_ptr_n   = wr_ptr;
        rd_ptr_n   = rd_ptr;
        inflight_n = inflight;
        error_n    = error;

        if (wr_en)
            wr_ptr_n = wr_ptr + CNT_W'(1);
        if (out_fire)
            rd_ptr_n = rd_ptr + CNT_W'(1);

        if (result_valid && full)
            error_n[0] = 1'b1;
        if (result_valid && (inflight == '0))
            error_n[1] = 1'b1;

        // Unexpected results saturate at zero instead of underflowing.
        if (result_valid && !issue_fire) begin
            if (inflight != '0)
                inflight_n = inflight - CNT_W'(1);
        end else if (issue_fire && !result_valid) begin
            inflight_n = inflight + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            inflight <= '0;
            error    <= '0;
        end else begin
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            inflight <= inflight_n;
            error    <= error_n;
        end
    end

    // Line storage carries no reset; contents are qualified by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr[ADDR_W-1:0]] <= result;
    end

`ifdef FLOAT_VECTOR_RESULT_COLLECTOR_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            lines_delivered <= '0;
            stall_cycles    <= '0;
        end else begin
            if (out_fire)
                lines_delivered <= lines_delivered + 32'(1);
            if (out_valid && !out_ready)
                stall_cycles <= stall_cycles + 32'(1);
        end
    end
`endif

endmodule

// File: tb/tb_float_vector_result_collector.sv
// Directed bench for float_vector_result_collector with a queue-based reference model checked every cycle.
module tb_float_vector_result_collector;

    localparam int unsigned VPL   = 16;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned LW    = 32 * VPL;

    logic              clk;
    logic              reset;
    logic              issue_valid;
    logic              issue_ready;
    logic [LW-1:0]     result;
    logic              result_valid;
    logic [LW-1:0]     out_data;
    logic              out_valid;
    logic              out_ready;
    logic [CNT_W-1:0]  occupancy;
    logic [CNT_W-1:0]  inflight;
    logic [1:0]        error;
`ifdef FLOAT_VECTOR_RESULT_COLLECTOR_STATS_EN
    logic [31:0]       lines_delivered;
    logic [31:0]       stall_cycles;
`endif

    float_vector_result_collector #(
        .VALUES_PER_LINE(VPL),
        .DEPTH(DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .issue_valid(issue_valid),
        .issue_ready(issue_ready),
        .result(result),
        .result_valid(result_valid),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .occupancy(occupancy),
        .inflight(inflight),
        .error(error)
`ifdef FLOAT_VECTOR_RESULT_COLLECTOR_STATS_EN
        ,
        .lines_delivered(lines_delivered),
        .stall_cycles(stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [LW-1:0] mk(input logic [31:0] v);
        logic [LW-1:0] l;
        for (int i = 0; i < int'(VPL); i++)
            l[i*32 +: 32] = v + 32'(i);
        return l;
    endfunction

    // Reference model: a bounded queue of lines plus a credit count.
    logic [LW-1:0] mq[$];
    int            m_inflight;
    logic [1:0]    m_err;
    longint        m_deliv;
    longint        m_stall;
    bit            m_fire;
    bit            m_full;
    bit            checking = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_inflight = 0;
            m_err      = 2'b00;
            m_deliv    = 0;
            m_stall    = 0;
        end else begin
            m_fire = issue_valid && ((mq.size() + m_inflight) < int'(DEPTH));
            m_full = (mq.size() == int'(DEPTH));
            if (mq.size() > 0) begin
                if (out_ready) begin
                    void'(mq.pop_front());
                    m_deliv++;
                end else begin
                    m_stall++;
                end
            end
            if (result_valid) begin
                if (m_full) m_err[0] = 1'b1;
                else        mq.push_back(result);
                if (m_inflight == 0) m_err[1] = 1'b1;
            end
            m_inflight = m_inflight + int'(m_fire) - int'(result_valid);
            if (m_inflight < 0) m_inflight = 0;
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
            if (mq.size() > 0) begin
                vectors++;
                if (out_data !== mq[0]) begin
                    miscompares++;
                    $display("FAIL out_data: got lane0 %0h expected lane0 %0h (t=%0t)",
                             out_data[31:0], mq[0][31:0], $time);
                end
            end
            chk("occupancy", 64'(occupancy), 64'(mq.size()));
            chk("inflight", 64'(inflight), 64'(m_inflight));
            chk("issue_ready", 64'(issue_ready), 64'((mq.size() + m_inflight) < int'(DEPTH)));
            chk("error", 64'(error), 64'(m_err));
`ifdef FLOAT_VECTOR_RESULT_COLLECTOR_STATS_EN
            chk("lines_delivered", 64'(lines_delivered), 64'(32'(m_deliv)));
            chk("stall_cycles", 64'(stall_cycles), 64'(32'(m_stall)));
`endif
        end
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    int            fires;
    int            exp_next;
    bit            prev_stall;
    logic [LW-1:0] prev_data;

    initial begin
        issue_valid  = 1'b0;
        result_valid = 1'b0;
        result       = '0;
        out_ready    = 1'b0;
        reset        = 1'b1;
        step();
        checking = 1'b1;
        step();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_issue_ready", 64'(issue_ready), 64'd1);
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_inflight", 64'(inflight), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        reset = 1'b0;

        // Single line through a five-cycle compute latency
        out_ready   = 1'b1;
        issue_valid = 1'b1;
        step();
        issue_valid = 1'b0;
        for (int c = 1; c < 5; c++) begin
            chk("single_inflight", 64'(inflight), 64'd1);
            step();
        end
        chk("single_inflight_c5", 64'(inflight), 64'd1);
        result_valid = 1'b1;
        result       = mk(32'h3F00_0000);
        step();
        result_valid = 1'b0;
        chk("single_valid_c6", 64'(out_valid), 64'd1);
        chk("single_lane0_c6", 64'(out_data[31:0]), 64'h3F00_0000);
        chk("single_inflight_c6", 64'(inflight), 64'd0);
        step();
        chk("single_occ_c7", 64'(occupancy), 64'd0);

        // Credit exhaustion with downstream stalled
        out_ready   = 1'b0;
        issue_valid = 1'b1;
        fires       = 0;
        for (int i = 0; i < 20; i++) begin
            if (issue_ready) fires++;
            step();
        end
        issue_valid = 1'b0;
        chk("credit_fires", 64'(fires), 64'd16);
        chk("credit_ready_low", 64'(issue_ready), 64'd0);
        result_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            result = mk(32'(100 + i));
            step();
        end
        result_valid = 1'b0;
        chk("credit_occ_full", 64'(occupancy), 64'd16);
        chk("credit_inflight0", 64'(inflight), 64'd0);
        chk("credit_ready_full", 64'(issue_ready), 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("credit_ready_back", 64'(issue_ready), 64'd1);
        out_ready = 1'b1;
        repeat (16) step();
        out_ready = 1'b0;

        // Ordering and stability under a 1,0,0 ready pattern
        issue_valid = 1'b1;
        repeat (8) step();
        issue_valid = 1'b0;
        exp_next   = 1;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int k = 0; k < 40; k++) begin
            result_valid = (k < 8);
            result       = mk(32'(k + 1));
            out_ready    = ((k % 3) == 0);
            if (prev_stall)
                chk("bp_stable", 64'(out_data == prev_data), 64'd1);
            if (out_valid && out_ready) begin
                chk("bp_order", 64'(out_data[31:0]), 64'(exp_next));
                exp_next++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            step();
        end
        result_valid = 1'b0;
        out_ready    = 1'b0;
        chk("bp_count", 64'(exp_next), 64'd9);

        // Issue and result in the same cycle hold inflight
        issue_valid = 1'b1;
        repeat (3) step();
        chk("steady_inflight3", 64'(inflight), 64'd3);
        result_valid = 1'b1;
        result       = mk(32'h55);
        step();
        chk("steady_hold3", 64'(inflight), 64'd3);
        issue_valid = 1'b0;
        repeat (3) step();
        result_valid = 1'b0;
        chk("steady_inflight0", 64'(inflight), 64'd0);
        out_ready = 1'b1;
        repeat (5) step();
        out_ready = 1'b0;

        // Write into a full buffer alongside a read is an overflow
        issue_valid = 1'b1;
        repeat (16) step();
        issue_valid  = 1'b0;
        result_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            result = mk(32'(200 + i));
            step();
        end
        out_ready = 1'b1;
        result    = mk(32'hBAD);
        step();
        result_valid = 1'b0;
        out_ready    = 1'b0;
        chk("ovf_err0", 64'(error[0]), 64'd1);
        chk("ovf_occ15", 64'(occupancy), 64'd15);
        chk("ovf_head", 64'(out_data[31:0]), 64'd201);
        out_ready = 1'b1;
        repeat (16) step();
        out_ready = 1'b0;

        // Spurious result after reset
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("clr_error", 64'(error), 64'd0);
        result_valid = 1'b1;
        result       = mk(32'h77);
        step();
        result_valid = 1'b0;
        chk("spur_error", 64'(error), 64'b10);
        chk("spur_valid", 64'(out_valid), 64'd1);
        chk("spur_lane0", 64'(out_data[31:0]), 64'h77);
        chk("spur_inflight", 64'(inflight), 64'd0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset in the middle of a stream
        reset = 1'b1;
        step();
        reset       = 1'b0;
        issue_valid = 1'b1;
        repeat (9) step();
        issue_valid  = 1'b0;
        result_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            result = mk(32'(300 + i));
            step();
        end
        result_valid = 1'b0;
        chk("mid_occ5", 64'(occupancy), 64'd5);
        chk("mid_inflight4", 64'(inflight), 64'd4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_occ", 64'(occupancy), 64'd0);
        chk("mid_rst_inflight", 64'(inflight), 64'd0);
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_ready", 64'(issue_ready), 64'd1);
        result_valid = 1'b1;
        result       = mk(32'h999);
        step();
        result_valid = 1'b0;
        chk("mid_late_err1", 64'(error[1]), 64'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

`ifdef FLOAT_VECTOR_RESULT_COLLECTOR_STATS_EN
        // Ten deliveries and seven stall cycles
        reset = 1'b1;
        step();
        reset       = 1'b0;
        issue_valid = 1'b1;
        repeat (10) step();
        issue_valid  = 1'b0;
        out_ready    = 1'b1;
        result_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            result = mk(32'(400 + i));
            step();
        end
        result_valid = 1'b0;
        out_ready    = 1'b0;
        repeat (7) step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("stats_delivered", 64'(lines_delivered), 64'd10);
        chk("stats_stalls", 64'(stall_cycles), 64'd7);
`endif

        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
